// File: rtl/camera_pwr_seq.sv
// ============================================================================
// Module   : camera_pwr_seq
// Brief    : Avalon-MM power-up/down sequencer for a MIPI camera sensor.
//            Optional interrupt output enabled by defining CAM_SEQ_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module camera_pwr_seq #(
    parameter int                 DELAY_W   = 16,
    parameter logic [DELAY_W-1:0] DELAY_RST = 16'd5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mipi_pwdn_n,
    output logic        mipi_reset_n,
    output logic        mipi_mclk_en
`ifdef CAM_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int                C_ST_W      = 3;
    localparam logic [C_ST_W-1:0] C_ST_OFF    = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_PWRUP  = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_CLKON  = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_ON     = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_RSTDN  = 3'd4;
    localparam logic [C_ST_W-1:0] C_ST_CLKOFF = 3'd5;

    logic               wr;
    logic               wr_ctrl;
    logic               wr_delay;
    logic               unused_wdata;

    logic [C_ST_W-1:0]  state_q, state_d;
    logic [DELAY_W-1:0] tmr_q, tmr_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] load_val;
    logic               expired;
    logic               power_req_q, power_req_d;
    logic               pwdn_n_q, pwdn_n_d;
    logic               mclk_en_q, mclk_en_d;
    logic               reset_n_q, reset_n_d;
    logic               irq_en_rd;
    logic               irq_pend_rd;

    assign wr           = chipselect & ~write_n;
    assign wr_ctrl      = wr && (address == 2'd0);
    assign wr_delay     = wr && (address == 2'd2);
    assign unused_wdata = ^writedata;

    // A programmed dwell of zero behaves as a single-cycle dwell.
    assign load_val = (delay_q == '0) ? '0 : delay_q - DELAY_W'(1);
    assign expired  = (tmr_q == '0);

    always_comb begin
        power_req_d = power_req_q;
        delay_d     = delay_q;
        if (wr_ctrl) begin
            power_req_d = writedata[0];
        end
        if (wr_delay) begin
            delay_d = writedata[DELAY_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            power_req_q <= 1'b0;
            delay_q     <= DELAY_RST;
        end else begin
            power_req_q <= power_req_d;
            delay_q     <= delay_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_ST_OFF;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Mid-sequence requests only reverse direction at dwell expiry.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            C_ST_OFF:    if (power_req_q)  state_d = C_ST_PWRUP;
            C_ST_PWRUP:  if (expired)      state_d = power_req_q ? C_ST_CLKON : C_ST_OFF;
            C_ST_CLKON:  if (expired)      state_d = power_req_q ? C_ST_ON    : C_ST_CLKOFF;
            C_ST_ON:     if (!power_req_q) state_d = C_ST_RSTDN;
            C_ST_RSTDN:  if (expired)      state_d = power_req_q ? C_ST_ON    : C_ST_CLKOFF;
            C_ST_CLKOFF: if (expired)      state_d = power_req_q ? C_ST_CLKON : C_ST_OFF;
            default:                       state_d = C_ST_OFF;
        endcase
        if (state_d != state_q) begin
            tmr_d = load_val;
        end else if (!expired && (state_q != C_ST_OFF) && (state_q != C_ST_ON)) begin
            tmr_d = tmr_q - DELAY_W'(1);
        end
    end

    // Pins decode the next state so they move on the same edge as the state.
    always_comb begin
        pwdn_n_d  = 1'b0;
        mclk_en_d = 1'b0;
        reset_n_d = 1'b0;
        case (state_d)
            C_ST_PWRUP:  pwdn_n_d = 1'b1;
            C_ST_CLKON:  begin pwdn_n_d = 1'b1; mclk_en_d = 1'b1; end
            C_ST_ON:     begin pwdn_n_d = 1'b1; mclk_en_d = 1'b1; reset_n_d = 1'b1; end
            C_ST_RSTDN:  begin pwdn_n_d = 1'b1; mclk_en_d = 1'b1; end
            C_ST_CLKOFF: pwdn_n_d = 1'b1;
            default:     pwdn_n_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwdn_n_q  <= 1'b0;
            mclk_en_q <= 1'b0;
            reset_n_q <= 1'b0;
        end else begin
            pwdn_n_q  <= pwdn_n_d;
            mclk_en_q <= mclk_en_d;
            reset_n_q <= reset_n_d;
        end
    end

    assign mipi_pwdn_n  = pwdn_n_q;
    assign mipi_mclk_en = mclk_en_q;
    assign mipi_reset_n = reset_n_q;

`ifdef CAM_SEQ_IRQ_EN
    logic wr_status;
    logic irq_set;
    logic irq_en_q, irq_en_d;
    logic irq_pend_q, irq_pend_d;

    assign wr_status = wr && (address == 2'd1);
    assign irq_set   = (state_d != state_q) && ((state_d == C_ST_ON) || (state_d == C_ST_OFF));

    always_comb begin
        irq_en_d   = wr_ctrl ? writedata[1] : irq_en_q;
        irq_pend_d = irq_set | (irq_pend_q & ~(wr_status & writedata[4]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_en_rd   = irq_en_q;
    assign irq_pend_rd = irq_pend_q;
    assign irq         = irq_pend_q & irq_en_q;
`else
    assign irq_en_rd   = 1'b0;
    assign irq_pend_rd = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {30'd0, irq_en_rd, power_req_q};
            2'd1:    readdata = {27'd0, irq_pend_rd, (state_q == C_ST_ON), state_q};
            2'd2:    readdata = 32'(delay_q);
            default: readdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_camera_pwr_seq.sv
// ============================================================================
// Module   : tb_camera_pwr_seq
// Brief    : Self-checking bench for camera_pwr_seq with a level-based model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_camera_pwr_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        mipi_pwdn_n, mipi_reset_n, mipi_mclk_en;
`ifdef CAM_SEQ_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    camera_pwr_seq dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .mipi_pwdn_n  (mipi_pwdn_n),
        .mipi_reset_n (mipi_reset_n),
        .mipi_mclk_en (mipi_mclk_en)
`ifdef CAM_SEQ_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    // Model: the sensor "level" (0..3 pins up) walks one step per dwell
    // toward the requested end (0 or 3); up/down records travel direction.
    int m_level, m_tmr, m_delay;
    bit m_up, m_req, m_en, m_pend;
    int n_level, n_tmr, n_delay;
    bit n_up, n_req, n_en, n_pend;

    always_comb begin
        int tgt, d1;
        bit mv, set, clr;
        n_level = m_level; n_tmr = m_tmr; n_up = m_up;
        n_req = m_req; n_en = m_en; n_delay = m_delay;
        mv = 1'b0; set = 1'b0; clr = 1'b0;
        d1  = (m_delay == 0) ? 1 : m_delay;
        tgt = m_req ? 3 : 0;
        if (m_level == 0 || m_level == 3) mv = (tgt != m_level);
        else if (m_tmr == 0)              mv = 1'b1;
        else                              n_tmr = m_tmr - 1;
        if (mv) begin
            if (tgt > m_level) begin n_level = m_level + 1; n_up = 1'b1; end
            else               begin n_level = m_level - 1; n_up = 1'b0; end
            n_tmr = d1 - 1;
            set   = (n_level == 0 || n_level == 3);
        end
        if (chipselect && !write_n) begin
            case (address)
                2'd0: begin n_req = writedata[0]; n_en = writedata[1]; end
                2'd1: clr = writedata[4];
                2'd2: n_delay = int'(writedata[15:0]);
                default: ;
            endcase
        end
        n_pend = set | (m_pend & ~clr);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_level <= 0; m_tmr <= 0; m_up <= 1'b0; m_req <= 1'b0;
            m_en <= 1'b0; m_pend <= 1'b0; m_delay <= 5000;
        end else begin
            m_level <= n_level; m_tmr <= n_tmr; m_up <= n_up; m_req <= n_req;
            m_en <= n_en; m_pend <= n_pend; m_delay <= n_delay;
        end
    end

    function automatic logic [2:0] exp_pins();
        return {m_level >= 1, m_level >= 2, m_level >= 3};
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a);
        logic [2:0] code;
        logic       pend_v, en_v;
        case (m_level)
            0:       code = 3'd0;
            1:       code = m_up ? 3'd1 : 3'd5;
            2:       code = m_up ? 3'd2 : 3'd4;
            default: code = 3'd3;
        endcase
`ifdef CAM_SEQ_IRQ_EN
        pend_v = m_pend; en_v = m_en;
`else
        pend_v = 1'b0;   en_v = 1'b0;
`endif
        case (a)
            2'd0:    return {30'd0, en_v, m_req};
            2'd1:    return {27'd0, pend_v, m_level == 3, code};
            2'd2:    return 32'(m_delay);
            default: return 32'd0;
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #12;
        if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== 3'b000) begin
            errors++; $display("FAIL reset_pins_during got=%b want=000",
                               {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n});
        end
        checks++;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== 3'b000) begin
            errors++; $display("FAIL reset_pins_after got=%b want=000",
                               {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n});
        end
        checks++;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); #1; rd = readdata;
            if (rd !== ((a == 2) ? 32'd5000 : 32'd0)) begin
                errors++; $display("FAIL reset_reg%0d got=%h want=%h", a, rd,
                                   (a == 2) ? 32'd5000 : 32'd0);
            end
            checks++;
        end
        address = 2'd1;
    endtask

    task automatic test_powerup();
        logic [2:0] want;
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            want = {k >= 1, k >= 5, k >= 9};
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== want) begin
                errors++; $display("FAIL powerup_k%0d got=%b want=%b", k,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, want);
            end
            checks++;
        end
        if (readdata !== 32'h0000_000B) begin
            errors++; $display("FAIL powerup_status got=%h want=0000000b", readdata);
        end
        checks++;
    endtask

    task automatic test_powerdown();
        logic [2:0] want;
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            want = {k < 7, k < 4, k < 1};
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== want) begin
                errors++; $display("FAIL powerdown_k%0d got=%b want=%b", k,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, want);
            end
            checks++;
        end
        if (readdata[2:0] !== 3'd0) begin
            errors++; $display("FAIL powerdown_state got=%0d want=0", readdata[2:0]);
        end
        checks++;
    endtask

    task automatic test_abort();
        bit saw_rst = 1'b0;
        bus_write(2'd2, 32'd10);
        bus_write(2'd0, 32'd1);
        repeat (13) @(posedge clk);
        #1;
        if (readdata[2:0] !== 3'd2) begin
            errors++; $display("FAIL abort_in_clkon got=%0d want=2", readdata[2:0]);
        end
        checks++;
        bus_write(2'd0, 32'd0);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mipi_reset_n) saw_rst = 1'b1;
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== exp_pins()) begin
                errors++; $display("FAIL abort_pins_k%0d got=%b want=%b", k,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, exp_pins());
            end
            checks++;
        end
        if (saw_rst) begin
            errors++; $display("FAIL abort_reset_n_rose got=1 want=0");
        end
        checks++;
        if (readdata !== 32'd0 || mipi_pwdn_n !== 1'b0) begin
            errors++; $display("FAIL abort_end_off got=%h pwdn=%b want=0 pwdn=0",
                               readdata, mipi_pwdn_n);
        end
        checks++;
    endtask

    task automatic test_delay_zero();
        logic [2:0] want;
        bus_write(2'd2, 32'h0001_0000);
        address = 2'd2; #1;
        if (readdata !== 32'd0) begin
            errors++; $display("FAIL delay_bit16 got=%h want=0", readdata);
        end
        checks++;
        bus_write(2'd0, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            want = {k >= 1, k >= 2, k >= 3};
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== want) begin
                errors++; $display("FAIL d0_up_k%0d got=%b want=%b", k,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, want);
            end
            checks++;
        end
        bus_write(2'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            want = {k < 3, k < 2, k < 1};
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== want) begin
                errors++; $display("FAIL d0_down_k%0d got=%b want=%b", k,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, want);
            end
            checks++;
        end
    endtask

`ifdef CAM_SEQ_IRQ_EN
    task automatic test_irq();
        bus_write(2'd1, 32'h10);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'd3);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (irq !== (k >= 5)) begin
                errors++; $display("FAIL irq_rise_k%0d got=%b want=%b", k, irq, k >= 5);
            end
            checks++;
        end
        bus_write(2'd1, 32'h10);
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_w1c got=%b want=0", irq);
        end
        checks++;
        bus_write(2'd0, 32'd2);
        repeat (3) @(negedge clk);
        bus_write(2'd1, 32'h10);
        if (irq !== 1'b1 || readdata !== 32'h10) begin
            errors++; $display("FAIL irq_set_wins got irq=%b st=%h want irq=1 st=10",
                               irq, readdata);
        end
        checks++;
        bus_write(2'd1, 32'h10);
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_final_clear got=%b want=0", irq);
        end
        checks++;
    endtask
`endif

    task automatic test_reset_mid();
        bus_write(2'd2, 32'd10);
        bus_write(2'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== 3'b100) begin
            errors++; $display("FAIL rstmid_pre got=%b want=100",
                               {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n});
        end
        checks++;
        #1 reset = 1'b1;
        #1;
        if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== 3'b000 || readdata !== 32'd0) begin
            errors++; $display("FAIL rstmid_async got=%b st=%h want=000 st=0",
                               {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, readdata);
        end
        checks++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_random();
        int r;
        bus_write(2'd2, 32'd2);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 9);
            chipselect = 1'b0; write_n = 1'b1;
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            case (r)
                0, 1: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd0; end
                2: begin
                    chipselect = 1'b1; write_n = 1'b0; address = 2'd2;
                    writedata = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
                end
                3: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd1; end
                4: begin chipselect = 1'b1; write_n = 1'b0; address = 2'd3; end
                default: write_n = ($urandom_range(0, 1) == 1);
            endcase
            @(posedge clk); #1;
            if ({mipi_pwdn_n, mipi_mclk_en, mipi_reset_n} !== exp_pins()) begin
                errors++; $display("FAIL rand_pins_i%0d got=%b want=%b", i,
                                   {mipi_pwdn_n, mipi_mclk_en, mipi_reset_n}, exp_pins());
            end
            checks++;
            if (readdata !== exp_read(address)) begin
                errors++; $display("FAIL rand_read_i%0d addr=%0d got=%h want=%h", i,
                                   address, readdata, exp_read(address));
            end
            checks++;
`ifdef CAM_SEQ_IRQ_EN
            if (irq !== (m_pend & m_en)) begin
                errors++; $display("FAIL rand_irq_i%0d got=%b want=%b", i, irq, m_pend & m_en);
            end
            checks++;
`endif
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_abort();
        test_delay_zero();
`ifdef CAM_SEQ_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
